// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed byte stream and writes
// 32-bit words into instruction memory, then releases the core reset.
module program_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    state_t      state_n;
    logic [15:0] word_cnt;
    logic [15:0] word_cnt_inc;
    logic [15:0] n_words;
    logic [15:0] hdr_n;
    logic [7:0]  cnt_lo;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        core_rst_q;
    logic        hdr_bad;

    assign hdr_n        = {byte_data, cnt_lo};
    assign hdr_bad      = (hdr_n == 16'd0) ||
                          ({1'b0, hdr_n} > DEPTH_W);
    assign word_cnt_inc = word_cnt + 16'd1;

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and decoded handshake/status outputs.
    always_comb begin
        state_n    = state;
        byte_ready = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_n = S_HDR0;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_HDR0;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_n = S_HDR0;
            end
            S_HDR0: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_n = S_HDR1;
            end
            S_HDR1: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    state_n = hdr_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && byte_idx == 2'd3) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                if (word_cnt_inc == n_words) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_DATA;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: header capture, byte assembly, write address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt <= '0;
            n_words  <= '0;
            cnt_lo   <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        word_cnt <= '0;
                        byte_idx <= '0;
                    end
                end
                S_HDR0: begin
                    if (byte_valid) cnt_lo <= byte_data;
                end
                S_HDR1: begin
                    if (byte_valid) n_words <= hdr_n;
                end
                S_DATA: begin
                    if (byte_valid) begin
                        if (byte_idx == 2'd3) begin
                            wdata_q  <= {byte_data, word_buf};
                            addr_q   <= {14'd0, word_cnt, 2'b00};
                            byte_idx <= '0;
                        end else begin
                            // Lower lanes arrive first; shift right.
                            word_buf <= {byte_data, word_buf[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_cnt_inc;
                    byte_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Core reset release registered from the next state, glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst_q <= 1'b0;
        end else begin
            core_rst_q <= (state_n == S_DONE);
        end
    end

endmodule
